// File: rtl/boot_loader.sv
// Streams a big-endian program image into instruction memory and holds the
// CPU in reset until every word of the image has been written.
module boot_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_im_we,
    output logic [31:0] o_im_addr,
    output logic [31:0] o_im_data,
    output logic        o_cpu_rst_n,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned IDX_W    = ADDR_W + 1;
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    logic [7:0]         r_hdr_hi;
    logic [15:0]        r_count;
    logic [IDX_W-1:0]   r_word_idx;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_asm;
    logic               r_ready;
    logic               r_busy;
    logic               r_im_we;
    logic [31:0]        r_im_addr;
    logic [31:0]        r_im_data;
    logic               r_cpu_rst_n;
    logic               r_done;
    logic               r_err;

    state_t             w_state;
    logic [7:0]         w_hdr_hi;
    logic [15:0]        w_count;
    logic [IDX_W-1:0]   w_word_idx;
    logic [1:0]         w_byte_cnt;
    logic [23:0]        w_asm;
    logic               w_ready;
    logic               w_busy;
    logic               w_im_we;
    logic [31:0]        w_im_addr;
    logic [31:0]        w_im_data;
    logic               w_cpu_rst_n;
    logic               w_done;
    logic               w_err;
    logic               w_accept;
    logic [15:0]        w_n_full;
    logic               w_last_word;

    assign w_accept    = i_byte_valid & r_ready;
    assign w_n_full    = {r_hdr_hi, i_byte};
    assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_count);

    // State and all registered outputs; every output flop is reset here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_HDR0;
            r_hdr_hi    <= 8'd0;
            r_count     <= 16'd0;
            r_word_idx  <= '0;
            r_byte_cnt  <= 2'd0;
            r_asm       <= 24'd0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b1;
            r_im_we     <= 1'b0;
            r_im_addr   <= 32'd0;
            r_im_data   <= 32'd0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_hdr_hi    <= w_hdr_hi;
            r_count     <= w_count;
            r_word_idx  <= w_word_idx;
            r_byte_cnt  <= w_byte_cnt;
            r_asm       <= w_asm;
            r_ready     <= w_ready;
            r_busy      <= w_busy;
            r_im_we     <= w_im_we;
            r_im_addr   <= w_im_addr;
            r_im_data   <= w_im_data;
            r_cpu_rst_n <= w_cpu_rst_n;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    // Next-state and next-output decode; i_start overrides any byte acceptance.
    always_comb begin
        w_state     = r_state;
        w_hdr_hi    = r_hdr_hi;
        w_count     = r_count;
        w_word_idx  = r_word_idx;
        w_byte_cnt  = r_byte_cnt;
        w_asm       = r_asm;
        w_im_we     = 1'b0;
        w_im_addr   = r_im_addr;
        w_im_data   = r_im_data;
        w_cpu_rst_n = r_cpu_rst_n;
        w_done      = r_done;
        w_err       = r_err;

        if (i_start) begin
            w_state     = S_HDR0;
            w_word_idx  = '0;
            w_byte_cnt  = 2'd0;
            w_asm       = 24'd0;
            w_cpu_rst_n = 1'b0;
            w_done      = 1'b0;
            w_err       = 1'b0;
        end else begin
            case (r_state)
                S_HDR0: begin
                    if (w_accept) begin
                        w_hdr_hi = i_byte;
                        w_state  = S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_accept) begin
                        w_count    = w_n_full;
                        w_word_idx = '0;
                        w_byte_cnt = 2'd0;
                        if (w_n_full == 16'd0) begin
                            w_state     = S_DONE;
                            w_done      = 1'b1;
                            w_cpu_rst_n = 1'b1;
                        end else if (32'(w_n_full) > CAPACITY) begin
                            w_state = S_ERR;
                            w_err   = 1'b1;
                        end else begin
                            w_state = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        w_asm      = {r_asm[15:0], i_byte};
                        w_byte_cnt = r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            w_im_we    = 1'b1;
                            w_im_data  = {r_asm, i_byte};
                            w_im_addr  = BASE_ADDR + 32'({r_word_idx, 2'b00});
                            w_word_idx = r_word_idx + IDX_W'(1);
                            if (w_last_word) begin
                                w_state = S_DONE;
                            end
                        end
                    end
                end
                // Release lags the final write by one cycle so no fetch sees a pending write.
                S_DONE: begin
                    w_done      = 1'b1;
                    w_cpu_rst_n = 1'b1;
                end
                S_ERR: begin
                    w_err       = 1'b1;
                    w_cpu_rst_n = 1'b0;
                end
                default: begin
                    w_state = S_HDR0;
                end
            endcase
        end

        w_ready = (w_state == S_HDR0) || (w_state == S_HDR1) || (w_state == S_LOAD);
        w_busy  = w_ready;
    end

    assign o_byte_ready = r_ready;
    assign o_busy       = r_busy;
    assign o_im_we      = r_im_we;
    assign o_im_addr    = r_im_addr;
    assign o_im_data    = r_im_data;
    assign o_cpu_rst_n  = r_cpu_rst_n;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized scoreboard bench for boot_loader: the driver predicts each
// memory write from the program image, a monitor pops and compares them.
module tb_boot_loader;

    localparam int unsigned ADDR_W = 8;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          CAP    = 1 << ADDR_W;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready;
    logic        o_im_we;
    logic [31:0] o_im_addr;
    logic [31:0] o_im_data;
    logic        o_cpu_rst_n;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    exp_t        q[$];
    logic [31:0] prog[CAP];
    logic [31:0] last_addr = 32'hFFFF_FFFF;

    boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_im_we      (o_im_we),
        .o_im_addr    (o_im_addr),
        .o_im_data    (o_im_data),
        .o_cpu_rst_n  (o_cpu_rst_n),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (i_rst_n === 1'b1 && o_im_we === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                         o_im_addr, o_im_data);
            end else begin
                e = q.pop_front();
                chk("wr_addr", o_im_addr, e.a);
                chk("wr_data", o_im_data, e.d);
                chk("wr_cycle", 32'(cyc), 32'(e.c));
                last_addr = o_im_addr;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit push, input exp_t e, output bit ok);
        int n = 0;
        ok = 1'b0;
        i_byte = b;
        i_byte_valid = 1'b1;
        while (!o_byte_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (o_byte_ready) begin
            if (push) begin
                e.c = cyc + 1;
                q.push_back(e);
            end
            @(negedge i_clk);
            ok = 1'b1;
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL byte_timeout: ready stayed 0 for byte 0x%02h, expected 1", b);
        end
        i_byte_valid = 1'b0;
    endtask

    // Sends header N then the first nbytes-2 payload bytes of prog[].
    task automatic load(input int n, input int nbytes, input int gapmax);
        for (int k = 0; k < nbytes; k++) begin
            logic [7:0] b;
            bit         push;
            bit         ok;
            exp_t       e;
            int         w;
            int         g;
            w = (k >= 2) ? (k - 2) / 4 : 0;
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            repeat (g) @(negedge i_clk);
            if (k == 0)      b = 8'(n >> 8);
            else if (k == 1) b = 8'(n);
            else             b = 8'(prog[w] >> (8 * (3 - ((k - 2) % 4))));
            push = (k >= 2) && (((k - 2) % 4) == 3) && (n <= CAP);
            e.a  = BASE + 32'(4 * w);
            e.d  = prog[w];
            e.c  = 0;
            send_byte(b, push, e, ok);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic randomize_prog(input int n);
        for (int i = 0; i < n; i++) prog[i] = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_byte_valid = 1'b0;
        i_byte = 8'd0;
        repeat (3) @(negedge i_clk);
        chk("rst_ready", 32'(o_byte_ready), 32'd1);
        chk("rst_busy",  32'(o_busy), 32'd1);
        chk("rst_we",    32'(o_im_we), 32'd0);
        chk("rst_addr",  o_im_addr, 32'd0);
        chk("rst_data",  o_im_data, 32'd0);
        chk("rst_cpu",   32'(o_cpu_rst_n), 32'd0);
        chk("rst_done",  32'(o_done), 32'd0);
        chk("rst_err",   32'(o_err), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_rst_ready", 32'(o_byte_ready), 32'd1);

        // Directed two-word program, gap-free
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h0800_0000;
        load(2, 10, 0);
        chk("last_we",       32'(o_im_we), 32'd1);
        chk("held_cpu",      32'(o_cpu_rst_n), 32'd0);
        chk("held_done",     32'(o_done), 32'd0);
        @(negedge i_clk);
        chk("release_cpu",   32'(o_cpu_rst_n), 32'd1);
        chk("release_done",  32'(o_done), 32'd1);
        chk("done_ready",    32'(o_byte_ready), 32'd0);
        chk("done_busy",     32'(o_busy), 32'd0);
        i_byte_valid = 1'b1;
        i_byte = 8'hA5;
        repeat (4) @(negedge i_clk);
        i_byte_valid = 1'b0;
        chk("done_hold", 32'(o_done), 32'd1);

        // Empty program
        pulse_start();
        chk("start_cpu", 32'(o_cpu_rst_n), 32'd0);
        chk("start_done", 32'(o_done), 32'd0);
        load(0, 2, 0);
        chk("n0_done",  32'(o_done), 32'd1);
        chk("n0_cpu",   32'(o_cpu_rst_n), 32'd1);
        chk("n0_ready", 32'(o_byte_ready), 32'd0);

        // Over-capacity header
        pulse_start();
        load(CAP + 1, 2, 0);
        chk("ovf_err",   32'(o_err), 32'd1);
        chk("ovf_ready", 32'(o_byte_ready), 32'd0);
        chk("ovf_cpu",   32'(o_cpu_rst_n), 32'd0);
        chk("ovf_done",  32'(o_done), 32'd0);
        chk("ovf_busy",  32'(o_busy), 32'd0);

        // Full-capacity program
        pulse_start();
        chk("restart_err", 32'(o_err), 32'd0);
        randomize_prog(CAP);
        load(CAP, 2 + 4 * CAP, 0);
        @(negedge i_clk);
        chk("cap_last_addr", last_addr, BASE + 32'(4 * (CAP - 1)));
        chk("cap_done", 32'(o_done), 32'd1);
        chk("cap_err",  32'(o_err), 32'd0);

        // Three words with random valid gaps, then the same image gap-free
        randomize_prog(3);
        pulse_start();
        load(3, 14, 5);
        @(negedge i_clk);
        chk("gap_done", 32'(o_done), 32'd1);
        pulse_start();
        load(3, 14, 0);
        @(negedge i_clk);
        chk("nogap_done", 32'(o_done), 32'd1);

        // Restart after six payload bytes: only word 0 is written
        randomize_prog(2);
        pulse_start();
        load(2, 8, 0);
        pulse_start();
        chk("abort_busy",  32'(o_busy), 32'd1);
        chk("abort_ready", 32'(o_byte_ready), 32'd1);
        chk("abort_cpu",   32'(o_cpu_rst_n), 32'd0);
        chk("abort_done",  32'(o_done), 32'd0);
        chk("abort_sb",    32'(q.size()), 32'd0);
        randomize_prog(1);
        load(1, 6, 0);
        @(negedge i_clk);
        chk("fresh_addr", last_addr, BASE);
        chk("fresh_done", 32'(o_done), 32'd1);

        // Asynchronous reset while the first write strobe is high
        randomize_prog(2);
        pulse_start();
        load(2, 6, 0);
        #3 i_rst_n = 1'b0;
        #1;
        chk("arst_we",    32'(o_im_we), 32'd0);
        chk("arst_cpu",   32'(o_cpu_rst_n), 32'd0);
        chk("arst_ready", 32'(o_byte_ready), 32'd1);
        chk("arst_busy",  32'(o_busy), 32'd1);
        chk("arst_addr",  o_im_addr, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("arst_rel_ready", 32'(o_byte_ready), 32'd1);
        randomize_prog(1);
        load(1, 6, 0);
        @(negedge i_clk);
        chk("arst_reload_done", 32'(o_done), 32'd1);
        chk("arst_reload_addr", last_addr, BASE);

        repeat (3) @(negedge i_clk);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Program loader sitting directly upstream of the single-cycle CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions.
- Writes each instruction into the instruction-memory write port.
- Holds the CPU in reset (drives its i_rst_n) until the whole program is loaded, then releases it.

Parameters:
- ADDR_W, 8: word-address width of instruction memory; capacity = 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000: byte address of first instruction written; must be 4-byte aligned.

Ports:
- i_clk  input  1  system clock, all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  single-cycle pulse; restarts a load from header
- i_byte_valid  input  1  upstream byte present
- i_byte  input  8  upstream byte
- o_byte_ready  output  1  loader can accept byte this cycle
- o_im_we  output  1  instruction-memory write strobe, one cycle per word
- o_im_addr  output  32  byte address of word being written
- o_im_data  output  32  instruction word being written
- o_cpu_rst_n  output  1  active-low reset to CPU (PC, RF); low while loading
- o_busy  output  1  load in progress (HDR0/HDR1/LOAD)
- o_done  output  1  program loaded, CPU running
- o_err  output  1  header word count exceeds capacity

Behaviour:
- Handshake: a byte is accepted on a rising edge when i_byte_valid & o_byte_ready. i_byte must be stable while valid is high.
- o_byte_ready is registered/state-decoded, and is 1 only in HDR0, HDR1 and LOAD.
- Stream format: 2-byte word count N, big-endian (first byte = N[15:8]), followed by 4*N bytes, each word big-endian (first byte -> [31:24]).
- States:
  - HDR0: latch N[15:8], go to HDR1.
  - HDR1: latch N[7:0] and evaluate the complete N. N==0 -> DONE. N > 2^ADDR_W -> ERR. Otherwise -> LOAD, with word_idx=0 and byte_cnt=0.
  - LOAD: shift each accepted byte into a 32-bit assembly register; byte_cnt is a 2-bit counter that wraps. On acceptance of the 4th byte, register o_im_data = assembled word and o_im_addr = BASE_ADDR + {word_idx,2'b00}; o_im_we=1 for exactly the next cycle. Then word_idx++. After the write for word N-1, the state is DONE on the same edge as the write.
  - DONE: o_done=1, o_cpu_rst_n=1, ready=0. Further stream bytes are not accepted.
  - ERR: o_err=1, o_cpu_rst_n=0, ready=0, no memory writes.
- Write-to-release latency: o_im_we for the last word is high in cycle t; o_cpu_rst_n rises at the edge ending cycle t. The CPU therefore never fetches while a write is pending.
- Back-to-back bytes are allowed: ready stays 1 during a write cycle. The next word's bytes may be accepted in the same cycle that o_im_we is high, because the output register is separate from the assembly register.
- i_start:
  - In any state, on the next edge go to HDR0; clear word_idx, byte_cnt, o_done and o_err; drive o_cpu_rst_n=0.
  - Partial words are discarded.
  - If i_start coincides with a byte acceptance, i_start wins and the byte is dropped.
  - If it coincides with a pending o_im_we cycle, that write still completes.
- Wrap-around: word_idx is ADDR_W+1 bits wide. Capacity check at header time guarantees no address wrap. Address arithmetic is 32-bit modulo.
- Reset (async, any time incl. mid-load):
  - State = HDR0 immediately, so loading is mandatory after power-up.
  - o_byte_ready=1, o_busy=1.
  - o_im_we=0, o_im_addr=0, o_im_data=0.
  - o_cpu_rst_n=0, o_done=0, o_err=0.
  - All counters 0.
- o_busy = state in {HDR0,HDR1,LOAD}. o_cpu_rst_n is a registered output, glitch-free.

Test Plan:
- Reset, then stream 00 02 | 20 08 00 05 | 08 00 00 00, valid every cycle -> writes (0x00,0x20080005), then (0x04,0x08000000). o_cpu_rst_n rises on the edge after the second o_im_we cycle; o_done=1.
- Header 00 00 -> no o_im_we. o_done=1 and o_cpu_rst_n=1 one cycle after the second header byte is accepted.
- ADDR_W=8, header 01 01 (N=257) -> o_err=1, ready=0, o_cpu_rst_n=0. Header 01 00 (N=256) is accepted, and its last write has address 0x3FC.
- Random valid gaps (valid low 0-5 cycles) on a 3-word program -> identical write sequence and data as the gap-free run. No write is issued on a non-accepted cycle.
- i_start pulsed after 6 of 8 payload bytes -> one write only (word 0). Return to HDR0, o_cpu_rst_n=0. A fresh 1-word load then writes at BASE_ADDR.
- Assert i_rst_n=0 mid-LOAD, asynchronously between edges -> o_im_we and o_cpu_rst_n drop to 0 immediately. After release, the loader is in HDR0 with ready=1.
